tm1640_frame_ctrl: RTL and testbench
====================================

TM1640_FRAME_CTRL -- requirements
Module: tm1640_frame_ctrl

Interface
REQ-001 Parameter BRIGHTNESS, default 4: brightness (0-7) for the power-on frame.
REQ-002 Parameter LATCH_TIMEOUT, default 255: cycles to wait for busy to rise after a latch.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 frame_valid  input  1  upstream frame offered.
REQ-006 frame_ready  output  1  high only in IDLE; the frame is accepted when frame_valid and frame_ready are both high.
REQ-007 digits  input  36  nine hex nibbles; digit i = digits[4i+3:4i], shown at LED address i.
REQ-008 dp  input  9  bit i lights the decimal point of digit i.
REQ-009 blank  input  9  bit i forces digit i segments (including dp) to 0x00.
REQ-010 bright  input  3  brightness for this frame.
REQ-011 disp_on  input  1  display on/off bit for this frame.
REQ-012 frame_done  output  1  one-cycle pulse after the control byte completes.
REQ-013 data_latch  output  1  byte-load strobe to the tm1640 driver.
REQ-014 data_in  output  8  byte to the driver.
REQ-015 data_stop_bit  output  1  high means the driver issues STOP after this byte.
REQ-016 busy  input  1  driver busy.
REQ-017 timeout_err  output  1  sticky error flag.

Function
REQ-018 On acceptance, digits, dp, blank, bright and disp_on SHALL be registered; input changes after that point have no effect on the frame.
REQ-019 A frame SHALL send exactly 12 bytes, in order:
- 0x40, stop=1
- 0xC0, stop=0
- data bytes 0..8, stop=0 except byte 8, which uses stop=1
- {4'b1000, disp_on, bright}, stop=1
REQ-020 Segment encoding, with bit0=a through bit6=g and bit7=dp:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- dp[i] ORs in 0x80; blank[i] overrides both to 0x00.
REQ-021 Byte handshake has two sub-states:
- SEND: drive data_in and data_stop_bit, hold data_latch=1 until busy is sampled high.
- WAIT: data_latch=0, stay until busy is sampled low; then advance to the next byte.
REQ-022 data_in and data_stop_bit SHALL stay stable from the first latch cycle until busy falls.
REQ-023 SEND SHALL NOT begin while busy=1.
REQ-024 Top states and transitions:
- BOOT → CMD → ADDR → DATA (index 0..8) → CTRL → DONE → IDLE.
- DONE lasts one cycle and pulses frame_done.
REQ-025 After reset, BOOT SHALL send one power-on frame without waiting for frame_valid:
- all digits blank (0x00);
- control byte 0x88|BRIGHTNESS[2:0].
- It SHALL pulse frame_done at the end.
REQ-026 frame_ready SHALL be 0 in every state except IDLE; frame_valid outside IDLE is held off, not dropped.
REQ-027 Back-to-back: if frame_valid=1 in IDLE, acceptance SHALL occur in that cycle, and the first SEND SHALL start the next cycle.
REQ-028 Timeout: if busy stays low for LATCH_TIMEOUT cycles in SEND, the block SHALL:
- set timeout_err=1;
- drop data_latch;
- abort the frame to IDLE without a frame_done pulse.
- timeout_err clears only on reset.
REQ-029 The data index counter SHALL be 4 bits and SHALL never exceed 8; the timeout counter SHALL be 8 bits and saturating.

Reset
REQ-030 While rst_n=0, outputs SHALL read:
- frame_ready=0, data_latch=0, data_in=0x00, data_stop_bit=0;
- frame_done=0, timeout_err=0.
REQ-031 While rst_n=0, state=BOOT and all counters=0.
REQ-032 Reset asserted mid-frame SHALL abort immediately, with no further latch; after release the power-on frame is resent.

Structure
REQ-033 Package tm1640_pkg SHALL hold:
- command constants CMD_DATA=0x40, CMD_ADDR0=0xC0, CMD_CTRL=0x80;
- the state enum typedef;
- the 16-entry segment table.
REQ-034 Sub-module seg7_hex_enc SHALL be purely combinational: nibble, dp, blank → 8-bit pattern.

Verification
Driver model for all scenarios: busy rises 2 cycles after latch, stays high 20 cycles.
REQ-035 Reset release, BRIGHTNESS=4 → bytes 40,C0, 00×9, 8C; stop bits 1,0,0×8,1,1; then frame_done pulse, frame_ready=1.
REQ-036 Frame digits=36'h987654321, dp=0, blank=0, bright=7, disp_on=1 → data bytes 06,5B,4F,66,6D,7D,07,7F,6F; control 8F.
REQ-037 digits=36'hFEDCBA000, dp=9'h001, blank=9'h002, bright=0, disp_on=0 → data bytes BF,00,3F,77,7C,39,5E,79,71; control 80.
REQ-038 Busy model never rises → after 255 cycles, timeout_err=1, data_latch=0, frame_ready=1, no frame_done.
REQ-039 frame_valid held high continuously:
- second frame accepted in the cycle after frame_done;
- digits changed mid-frame do not alter the current bytes;
- rst_n pulsed low at the 5th byte → data_latch=0 immediately, and the power-on frame restarts.

Source files
------------

// File: rtl/tm1640_pkg.sv
// Shared constants, state encodings and the hex-to-segment table for the TM1640 frame controller.
package tm1640_pkg;

    localparam int unsigned NUM_DIGITS = 9;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned TMO_W      = 8;

    localparam logic [7:0] CMD_DATA  = 8'h40;
    localparam logic [7:0] CMD_ADDR0 = 8'hC0;
    localparam logic [7:0] CMD_CTRL  = 8'h80;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CTRL,
        ST_DONE,
        ST_IDLE
    } state_e;

    typedef enum logic {
        PH_SEND,
        PH_WAIT
    } phase_e;

    // Entry n is the segment pattern of hex value n (bit0=a .. bit6=g).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational hex nibble to 7-segment pattern, with decimal point and blanking.
module seg7_hex_enc
    import tm1640_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble_i,
    input  logic               dp_i,
    input  logic               blank_i,
    output logic [7:0]         seg_c
);

    always_comb begin
        seg_c = SEG_TABLE[nibble_i] | {dp_i, 7'b000_0000};
        if (blank_i) begin
            seg_c = 8'h00;
        end
    end

endmodule

// File: rtl/tm1640_frame_ctrl.sv
// Frame sequencer for a TM1640 byte driver: power-on frame, then one 12-byte
// display frame per accepted request, with a per-byte latch/busy handshake.
module tm1640_frame_ctrl
    import tm1640_pkg::*;
#(
    parameter int unsigned BRIGHTNESS    = 4,
    parameter int unsigned LATCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [35:0] digits,
    input  logic [8:0]  dp,
    input  logic [8:0]  blank,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    output logic        frame_done,
    output logic        data_latch,
    output logic [7:0]  data_in,
    output logic        data_stop_bit,
    input  logic        busy,
    output logic        timeout_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LATCH_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             latch_q, latch_d;
    logic [7:0]       data_q, data_d;
    logic             stop_q, stop_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [35:0]      digits_q, digits_d;
    logic [8:0]       dp_q, dp_d;
    logic [8:0]       blank_q, blank_d;
    logic [2:0]       bright_q, bright_d;
    logic             disp_q, disp_d;

    logic             start_c;
    logic             byte_done_c;
    logic [IDX_W-1:0] nxt_idx_c;
    logic [3:0]       enc_nibble_c;
    logic             enc_dp_c;
    logic             enc_blank_c;
    logic [7:0]       enc_seg_c;
    logic [7:0]       ctrl_byte_c;

    // Digit selected for the next data byte to be loaded.
    always_comb begin
        nxt_idx_c    = (state_q == ST_DATA) ? idx_q + IDX_W'(1) : '0;
        enc_nibble_c = 4'(digits_q >> {nxt_idx_c, 2'b00});
        enc_dp_c     = 1'(dp_q >> nxt_idx_c);
        enc_blank_c  = 1'(blank_q >> nxt_idx_c);
        ctrl_byte_c  = CMD_CTRL | {4'b0000, disp_q, bright_q};
    end

    seg7_hex_enc u_enc (
        .nibble_i (enc_nibble_c),
        .dp_i     (enc_dp_c),
        .blank_i  (enc_blank_c),
        .seg_c    (enc_seg_c)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        latch_d     = latch_q;
        data_d      = data_q;
        stop_d      = stop_q;
        err_d       = err_q;
        digits_d    = digits_q;
        dp_d        = dp_q;
        blank_d     = blank_q;
        bright_d    = bright_q;
        disp_d      = disp_q;
        start_c     = 1'b0;
        byte_done_c = 1'b0;

        case (state_q)
            ST_BOOT: begin
                digits_d = '0;
                dp_d     = '0;
                blank_d  = '1;
                bright_d = 3'(BRIGHTNESS);
                disp_d   = 1'b1;
                start_c  = 1'b1;
            end
            ST_IDLE: begin
                if (frame_valid) begin
                    digits_d = digits;
                    dp_d     = dp;
                    blank_d  = blank;
                    bright_d = bright;
                    disp_d   = disp_on;
                    start_c  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Latch is only raised while the driver reports idle.
                if (phase_q == PH_SEND) begin
                    if (!latch_q) begin
                        latch_d = !busy;
                    end else if (busy) begin
                        latch_d = 1'b0;
                        phase_d = PH_WAIT;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        latch_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                    end else if (tmo_q != '1) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end else if (!busy) begin
                    byte_done_c = 1'b1;
                end
            end
        endcase

        if (start_c) begin
            state_d = ST_CMD;
            phase_d = PH_SEND;
            idx_d   = '0;
            tmo_d   = '0;
            data_d  = CMD_DATA;
            stop_d  = 1'b1;
            latch_d = !busy;
        end

        // Busy was just sampled low, so the next byte may latch immediately.
        if (byte_done_c) begin
            phase_d = PH_SEND;
            tmo_d   = '0;
            latch_d = 1'b1;
            case (state_q)
                ST_CMD: begin
                    state_d = ST_ADDR;
                    data_d  = CMD_ADDR0;
                    stop_d  = 1'b0;
                end
                ST_ADDR, ST_DATA: begin
                    if (state_q == ST_DATA && idx_q == IDX_LAST) begin
                        state_d = ST_CTRL;
                        data_d  = ctrl_byte_c;
                        stop_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = nxt_idx_c;
                        data_d  = enc_seg_c;
                        stop_d  = (nxt_idx_c == IDX_LAST);
                    end
                end
                default: begin
                    state_d = ST_DONE;
                    latch_d = 1'b0;
                end
            endcase
        end

        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            phase_q  <= PH_SEND;
            idx_q    <= '0;
            tmo_q    <= '0;
            latch_q  <= 1'b0;
            data_q   <= '0;
            stop_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            bright_q <= '0;
            disp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            latch_q  <= latch_d;
            data_q   <= data_d;
            stop_q   <= stop_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            bright_q <= bright_d;
            disp_q   <= disp_d;
        end
    end

    assign frame_ready   = ready_q;
    assign frame_done    = done_q;
    assign data_latch    = latch_q;
    assign data_in       = data_q;
    assign data_stop_bit = stop_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_tm1640_frame_ctrl.sv
// Bench for tm1640_frame_ctrl: busy-driver model, byte capture, table and random frames.
module tb_tm1640_frame_ctrl;

    typedef struct packed {
        logic [35:0]     digits;
        logic [8:0]      dp;
        logic [8:0]      blank;
        logic [2:0]      bright;
        logic            disp_on;
        logic [8:0][7:0] exp_data;
        logic [7:0]      exp_ctrl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [35:0] digits = '0;
    logic [8:0]  dp = '0;
    logic [8:0]  blank = '0;
    logic [2:0]  bright = '0;
    logic        disp_on = 1'b0;
    logic        busy = 1'b0;
    logic        frame_ready, frame_done, data_latch, data_stop_bit, timeout_err;
    logic [7:0]  data_in;

    int checks = 0;
    int failures = 0;

    bit drv_never = 1'b0;
    int pend = 0;
    int hold = 0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          acc_cyc = 0;
    int          stab_err = 0;
    logic        lat_prev = 1'b0;
    logic [8:0]  last_byte = '0;
    logic [8:0]  byte_q [$];
    logic [8:0]  exp_f [12];
    logic [7:0]  segref [16];
    vec_t        vecs [3];

    tm1640_frame_ctrl #(.BRIGHTNESS(4), .LATCH_TIMEOUT(255)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .digits        (digits),
        .dp            (dp),
        .blank         (blank),
        .bright        (bright),
        .disp_on       (disp_on),
        .frame_done    (frame_done),
        .data_latch    (data_latch),
        .data_in       (data_in),
        .data_stop_bit (data_stop_bit),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Driver model: busy rises 2 cycles after a latch and stays high 20 cycles.
    always @(posedge clk) begin
        #1;
        if (busy) begin
            hold = hold - 1;
            if (hold == 0) busy = 1'b0;
        end else if (pend == 2) begin
            busy = 1'b1;
            hold = 20;
            pend = 0;
        end else if (pend == 1) begin
            pend = 2;
        end else if (data_latch && !drv_never) begin
            pend = 1;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (data_latch && !lat_prev) begin
            byte_q.push_back({data_stop_bit, data_in});
        end else if (data_latch && lat_prev && {data_stop_bit, data_in} != last_byte) begin
            stab_err = stab_err + 1;
        end
        if (data_latch) last_byte = {data_stop_bit, data_in};
        lat_prev = data_latch;
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_valid && frame_ready) acc_cyc = cyc;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame computed straight from the byte-order and segment rules.
    task automatic build_expect(input logic [35:0] dg, input logic [8:0] dpv,
                                input logic [8:0] bl, input logic [2:0] br, input logic don);
        logic [3:0] nib;
        logic [7:0] seg;
        exp_f[0] = 9'h140;
        exp_f[1] = 9'h0C0;
        for (int i = 0; i < 9; i++) begin
            nib = 4'(dg >> (4 * i));
            seg = segref[nib];
            if (dpv[i]) seg = seg + 8'h80;
            if (bl[i]) seg = 8'h00;
            exp_f[2 + i] = {(i == 8), seg};
        end
        exp_f[11] = {1'b1, 4'b1000, don, br};
    endtask

    task automatic check_frame(input string tag, input int n);
        logic [63:0] act;
        chk($sformatf("%s_count", tag), 64'(byte_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            act = (i < byte_q.size()) ? 64'(byte_q[i]) : 64'hDEAD;
            chk($sformatf("%s_byte%0d", tag, i), act, 64'(exp_f[i]));
        end
    endtask

    task automatic wait_done(input string tag, input int prev, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done_cnt > prev) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("%s_done_seen", tag), 64'(ok), 64'd1);
    endtask

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (frame_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL %s_ready: got 0 expected 1", tag);
        end
    endtask

    task automatic pulse_frame(input string tag, input logic [35:0] dg, input logic [8:0] dpv,
                               input logic [8:0] bl, input logic [2:0] br, input logic don);
        wait_ready(tag);
        digits = dg; dp = dpv; blank = bl; bright = br; disp_on = don;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk($sformatf("%s_first_latch", tag), 64'(data_latch), 64'd1);
        // Scramble inputs after acceptance; the frame must not see them.
        digits = 36'({$urandom(), $urandom()});
        dp = 9'($urandom()); blank = 9'($urandom()); bright = 3'($urandom()); disp_on = 1'($urandom());
    endtask

    logic [35:0] rd;
    logic [8:0]  rdp, rbl;
    logic [2:0]  rbr;
    logic        rdon;
    int          prev;
    int          lat_cnt;
    bit          got5;

    initial begin
        segref = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

        vecs[0].digits = 36'h987654321; vecs[0].dp = 9'h000; vecs[0].blank = 9'h000;
        vecs[0].bright = 3'd7; vecs[0].disp_on = 1'b1; vecs[0].exp_ctrl = 8'h8F;
        vecs[0].exp_data = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
        vecs[1].digits = 36'hFEDCBA000; vecs[1].dp = 9'h001; vecs[1].blank = 9'h002;
        vecs[1].bright = 3'd0; vecs[1].disp_on = 1'b0; vecs[1].exp_ctrl = 8'h80;
        vecs[1].exp_data = {8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h3F, 8'h00, 8'hBF};
        vecs[2].digits = 36'h123456789; vecs[2].dp = 9'h1FF; vecs[2].blank = 9'h100;
        vecs[2].bright = 3'd3; vecs[2].disp_on = 1'b1; vecs[2].exp_ctrl = 8'h8B;
        vecs[2].exp_data = {8'h00, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD, 8'h87, 8'hFF, 8'hEF};

        // Reset values.
        repeat (3) tick();
        chk("rst_ready", 64'(frame_ready), 64'd0);
        chk("rst_latch", 64'(data_latch), 64'd0);
        chk("rst_data", 64'(data_in), 64'd0);
        chk("rst_stop", 64'(data_stop_bit), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        rst_n = 1'b1;

        // Power-on frame.
        exp_f = '{9'h140, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
                  9'h000, 9'h000, 9'h000, 9'h100, 9'h18C};
        wait_done("boot", 0, 1000);
        chk("boot_ready_during_done", 64'(frame_ready), 64'd0);
        check_frame("boot", 12);
        byte_q.delete();
        tick();
        chk("boot_ready_after", 64'(frame_ready), 64'd1);

        // Table-driven frames.
        foreach (vecs[v]) begin
            exp_f[0] = 9'h140;
            exp_f[1] = 9'h0C0;
            for (int i = 0; i < 9; i++) exp_f[2 + i] = {(i == 8), vecs[v].exp_data[i]};
            exp_f[11] = {1'b1, vecs[v].exp_ctrl};
            prev = done_cnt;
            pulse_frame($sformatf("vec%0d", v), vecs[v].digits, vecs[v].dp, vecs[v].blank,
                        vecs[v].bright, vecs[v].disp_on);
            wait_done($sformatf("vec%0d", v), prev, 1000);
            check_frame($sformatf("vec%0d", v), 12);
            byte_q.delete();
        end

        // Random frames against the reference model.
        for (int r = 0; r < 5; r++) begin
            rd = 36'({$urandom(), $urandom()});
            rdp = 9'($urandom()); rbl = 9'($urandom() & $urandom());
            rbr = 3'($urandom()); rdon = 1'($urandom());
            build_expect(rd, rdp, rbl, rbr, rdon);
            prev = done_cnt;
            pulse_frame($sformatf("rnd%0d", r), rd, rdp, rbl, rbr, rdon);
            wait_done($sformatf("rnd%0d", r), prev, 1000);
            check_frame($sformatf("rnd%0d", r), 12);
            byte_q.delete();
        end
        chk("err_clear_after_frames", 64'(timeout_err), 64'd0);

        // Back-to-back with frame_valid held high and inputs changing mid-frame.
        wait_ready("b2b");
        rd = 36'h0A1B2C3D4; rdp = 9'h0F0; rbl = 9'h003; rbr = 3'd5; rdon = 1'b1;
        build_expect(rd, rdp, rbl, rbr, rdon);
        digits = rd; dp = rdp; blank = rbl; bright = rbr; disp_on = rdon;
        frame_valid = 1'b1;
        prev = done_cnt;
        tick();
        rd = 36'h5F6E7D8C9; rdp = 9'h10A; rbl = 9'h040; rbr = 3'd2; rdon = 1'b1;
        digits = rd; dp = rdp; blank = rbl; bright = rbr; disp_on = rdon;
        wait_done("b2b_a", prev, 1000);
        check_frame("b2b_a", 12);
        byte_q.delete();
        build_expect(rd, rdp, rbl, rbr, rdon);
        tick();
        chk("b2b_accept_delay", 64'(acc_cyc - done_cyc), 64'd1);
        tick();
        chk("b2b_first_latch", 64'(data_latch), 64'd1);
        digits = 36'h111111111; dp = 9'h1FF; blank = 9'h000; bright = 3'd7; disp_on = 1'b0;
        got5 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (byte_q.size() >= 5) begin
                got5 = 1'b1;
                break;
            end
            tick();
        end
        chk("b2b_fifth_byte_seen", 64'(got5), 64'd1);
        check_frame("b2b_b", 5);

        // Reset in the middle of the fifth byte.
        frame_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_latch", 64'(data_latch), 64'd0);
        chk("midrst_data", 64'(data_in), 64'd0);
        chk("midrst_ready", 64'(frame_ready), 64'd0);
        repeat (3) tick();
        byte_q.delete();
        prev = done_cnt;
        rst_n = 1'b1;
        exp_f = '{9'h140, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
                  9'h000, 9'h000, 9'h000, 9'h100, 9'h18C};
        wait_done("reboot", prev, 1500);
        check_frame("reboot", 12);
        byte_q.delete();

        // Driver never answers: timeout after 255 latch cycles.
        wait_ready("tmo");
        for (int i = 0; i < 100 && busy; i++) tick();
        drv_never = 1'b1;
        prev = done_cnt;
        pulse_frame("tmo", 36'h000000000, 9'h000, 9'h000, 3'd1, 1'b1);
        lat_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (timeout_err) break;
            if (data_latch) lat_cnt = lat_cnt + 1;
            tick();
        end
        chk("tmo_err", 64'(timeout_err), 64'd1);
        chk("tmo_latch_cycles", 64'(lat_cnt), 64'd255);
        chk("tmo_latch_dropped", 64'(data_latch), 64'd0);
        chk("tmo_ready", 64'(frame_ready), 64'd1);
        chk("tmo_bytes", 64'(byte_q.size()), 64'd1);
        repeat (5) tick();
        chk("tmo_no_done", 64'(done_cnt - prev), 64'd0);
        chk("tmo_sticky", 64'(timeout_err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("tmo_cleared_by_reset", 64'(timeout_err), 64'd0);

        chk("latch_data_stable", 64'(stab_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
